// File: rtl/mult_chk_pkg.sv
// rtl/mult_chk_pkg.sv - shared types and helpers for the multiplier result checker
//
// Contents:
//   fail_code_t : outcome of one check (OK, parity-flag mismatch, data mismatch, unexpected result)
//   PAR_MAX_W   : widest operand accepted by parity_err()
//   parity_err  : 1 when a supplied even-parity bit does not match its data
package mult_chk_pkg;

    typedef enum logic [1:0] {
        CHK_OK         = 2'd0,
        CHK_PERR_FLAG  = 2'd1,
        CHK_DATA       = 2'd2,
        CHK_UNEXPECTED = 2'd3
    } fail_code_t;

    localparam int PAR_MAX_W = 64;

    // Callers zero-extend narrower operands; zero bits do not change the XOR.
    function automatic logic parity_err(input logic [PAR_MAX_W-1:0] data, input logic par);
        return (^data) != par;
    endfunction

endpackage

// File: rtl/mult_chk_fifo.sv
// rtl/mult_chk_fifo.sv - parametrised synchronous FIFO holding outstanding expectations
//
// Parameters: WIDTH (entry bits), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and data
//   pop, pop_data   read request; pop_data shows the head entry combinationally
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module mult_chk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_result_checker.sv
// rtl/mult_result_checker.sv - scoreboard comparing multiplier results against a reference model
//
// Optional feature macro: CHK_TIMEOUT_EN (watchdog on the oldest outstanding expectation)
// Parameters: W (operand width), DEPTH (outstanding expectations), SIGNED (1 signed multiply),
//             CNT_W (counter width), TIMEOUT (watchdog cycles)
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req, arg_a, arg_b             DUT request; rising edge of req pushes an expectation
//   arg_a_parity, arg_b_parity    even-parity bits supplied with the operands
//   result_rdy, result            DUT result strobe and product
//   result_parity                 DUT product parity
//   arg_parity_error              DUT input-parity-error flag
//   chk_valid, chk_fail, fail_code  registered per-check outcome pulse
//   pass_cnt, fail_cnt            saturating check counters
//   pending                       expectations currently queued
//   ovf_err, unexp_err, timeout_err sticky error flags
module mult_result_checker
    import mult_chk_pkg::*;
#(
    parameter int W       = 16,
    parameter int DEPTH   = 8,
    parameter int SIGNED  = 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [W-1:0]               arg_a,
    input  logic [W-1:0]               arg_b,
    input  logic                       arg_a_parity,
    input  logic                       arg_b_parity,
    input  logic                       result_rdy,
    input  logic [2*W-1:0]             result,
    input  logic                       result_parity,
    input  logic                       arg_parity_error,
    output logic                       chk_valid,
    output logic                       chk_fail,
    output logic [1:0]                 fail_code,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       ovf_err,
    output logic                       unexp_err,
    output logic                       timeout_err
);

    typedef struct packed {
        logic [2*W-1:0] product;
        logic           par;
        logic           perr;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic           req_prev;
    logic           push;
    logic           pop_now;
    logic           wd_fire;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    entry_t         new_entry;
    entry_t         head;
    fail_code_t     cmp_code;

    assign push = req && !req_prev;

    // Extending both operands to 2W bits first makes the truncated 2W-bit
    // product correct for both signed and unsigned multiplication.
    always_comb begin
        if (SIGNED != 0) begin
            ext_a = {{W{arg_a[W-1]}}, arg_a};
            ext_b = {{W{arg_b[W-1]}}, arg_b};
        end else begin
            ext_a = {{W{1'b0}}, arg_a};
            ext_b = {{W{1'b0}}, arg_b};
        end
    end

    always_comb begin
        new_entry.product = ext_a * ext_b;
        new_entry.par     = ^new_entry.product;
        new_entry.perr    = parity_err(PAR_MAX_W'(arg_a), arg_a_parity)
                          | parity_err(PAR_MAX_W'(arg_b), arg_b_parity);
    end

    // A result pops the head whenever one exists; the watchdog pops only when
    // no result arrives that cycle.
    assign pop_now = (result_rdy && !fifo_empty) || wd_fire;

    mult_chk_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (new_entry),
        .pop       (pop_now),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    // Case equality so that X/Z on any DUT output counts as a mismatch.
    always_comb begin
        cmp_code = CHK_OK;
        if (result_rdy) begin
            if (fifo_empty) begin
                cmp_code = CHK_UNEXPECTED;
            end else if (head.perr) begin
                if (arg_parity_error !== 1'b1) begin
                    cmp_code = CHK_PERR_FLAG;
                end
            end else if (arg_parity_error !== 1'b0) begin
                cmp_code = CHK_PERR_FLAG;
            end else if ((result !== head.product) || (result_parity !== head.par)) begin
                cmp_code = CHK_DATA;
            end
        end else if (wd_fire) begin
            cmp_code = CHK_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev  <= 1'b0;
            chk_valid <= 1'b0;
            chk_fail  <= 1'b0;
            fail_code <= CHK_OK;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            ovf_err   <= 1'b0;
            unexp_err <= 1'b0;
        end else begin
            req_prev  <= req;
            chk_valid <= 1'b0;
            chk_fail  <= 1'b0;
            fail_code <= CHK_OK;
            if (push && fifo_full && !pop_now) begin
                ovf_err <= 1'b1;
            end
            if (result_rdy && fifo_empty) begin
                unexp_err <= 1'b1;
            end
            if (result_rdy || wd_fire) begin
                chk_valid <= 1'b1;
                fail_code <= cmp_code;
                if (cmp_code == CHK_OK) begin
                    if (pass_cnt != '1) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end else begin
                    chk_fail <= 1'b1;
                    if (fail_cnt != '1) begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef CHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;

    // wd_cnt holds the cycles already waited, so firing at TIMEOUT-1 makes
    // the TIMEOUT-th waiting cycle the one that reports.
    assign wd_fire = !fifo_empty && !result_rdy && (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (fifo_empty || pop_now) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    // No watchdog is built; a negative TIMEOUT is meaningless, so this is constant 0.
    assign timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_mult_result_checker.sv
// tb/tb_mult_result_checker.sv - directed self-checking bench for mult_result_checker
`timescale 1ns/1ps
module tb_mult_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] arg_a;
    logic [15:0] arg_b;
    logic        arg_a_parity;
    logic        arg_b_parity;
    logic        result_rdy;
    logic [31:0] result;
    logic        result_parity;
    logic        arg_parity_error;

    logic        chk_valid,   u_chk_valid;
    logic        chk_fail,    u_chk_fail;
    logic [1:0]  fail_code,   u_fail_code;
    logic [15:0] pass_cnt,    u_pass_cnt;
    logic [15:0] fail_cnt,    u_fail_cnt;
    logic [3:0]  pending,     u_pending;
    logic        ovf_err,     u_ovf_err;
    logic        unexp_err,   u_unexp_err;
    logic        timeout_err, u_timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_result_checker #(.W(16), .DEPTH(8), .SIGNED(1), .CNT_W(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .arg_a(arg_a), .arg_b(arg_b),
        .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity),
        .result_rdy(result_rdy), .result(result), .result_parity(result_parity),
        .arg_parity_error(arg_parity_error),
        .chk_valid(chk_valid), .chk_fail(chk_fail), .fail_code(fail_code),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .pending(pending),
        .ovf_err(ovf_err), .unexp_err(unexp_err), .timeout_err(timeout_err)
    );

    mult_result_checker #(.W(16), .DEPTH(8), .SIGNED(0), .CNT_W(16), .TIMEOUT(64)) dut_u (
        .clk(clk), .rst(rst), .req(req), .arg_a(arg_a), .arg_b(arg_b),
        .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity),
        .result_rdy(result_rdy), .result(result), .result_parity(result_parity),
        .arg_parity_error(arg_parity_error),
        .chk_valid(u_chk_valid), .chk_fail(u_chk_fail), .fail_code(u_fail_code),
        .pass_cnt(u_pass_cnt), .fail_cnt(u_fail_cnt), .pending(u_pending),
        .ovf_err(u_ovf_err), .unexp_err(u_unexp_err), .timeout_err(u_timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [15:0] a, input logic [15:0] b, input logic pa, input logic pb);
        arg_a = a;
        arg_b = b;
        arg_a_parity = pa;
        arg_b_parity = pb;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_res(input logic [31:0] r, input logic rp, input logic pe);
        result = r;
        result_parity = rp;
        arg_parity_error = pe;
        result_rdy = 1'b1;
        @(posedge clk); #1;
        result_rdy = 1'b0;
    endtask

    // Products (i+1)*(i+2) and their hand-computed parities for the FIFO-order test.
    logic [31:0] ord_prod [8] = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56, 32'd72};
    logic        ord_par  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        req = 1'b0;
        arg_a = '0;
        arg_b = '0;
        arg_a_parity = 1'b0;
        arg_b_parity = 1'b0;
        result_rdy = 1'b0;
        result = '0;
        result_parity = 1'b0;
        arg_parity_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   chk_valid,   1'b0);
        chk("rst_pending", pending,     4'd0);
        chk("rst_pass",    pass_cnt,    16'd0);
        chk("rst_timeout", timeout_err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 3 * -5 = -15, all parities correct
        do_req(16'h0003, 16'hFFFB, 1'b0, 1'b1);
        chk("t1_pending", pending, 4'd1);
        do_res(32'hFFFF_FFF1, 1'b1, 1'b0);
        chk("t1_valid", chk_valid, 1'b1);
        chk("t1_fail",  chk_fail,  1'b0);
        chk("t1_code",  fail_code, 2'd0);
        chk("t1_pass",  pass_cnt,  16'd1);
        chk("t1_u_code", u_fail_code, 2'd2);
        @(posedge clk); #1;
        chk("t1_pulse", chk_valid, 1'b0);
        chk("t1_pend0", pending,   4'd0);

        // Bad parity on A: DUT must flag it, result is ignored
        do_req(16'h0001, 16'h0002, 1'b0, 1'b1);
        do_res(32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("t2a_code", fail_code, 2'd0);
        chk("t2a_pass", pass_cnt,  16'd2);
        do_req(16'h0001, 16'h0002, 1'b0, 1'b1);
        do_res(32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("t2b_fail", chk_fail,  1'b1);
        chk("t2b_code", fail_code, 2'd1);
        chk("t2b_fcnt", fail_cnt,  16'd1);

        // 0xFFFF * 0xFFFF: correct unsigned, wrong signed
        do_req(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        do_res(32'hFFFE_0001, 1'b0, 1'b0);
        chk("t3_u_code", u_fail_code, 2'd0);
        chk("t3_u_fail", u_chk_fail,  1'b0);
        chk("t3_s_code", fail_code,   2'd2);
        chk("t3_s_fcnt", fail_cnt,    16'd2);

        // Nine requests overflow an 8-deep queue; results must match request order
        for (int i = 0; i < 9; i++) begin
            logic [15:0] a, b;
            a = 16'(i + 1);
            b = 16'(i + 2);
            do_req(a, b, ^a, ^b);
        end
        chk("t4_ovf",  ovf_err, 1'b1);
        chk("t4_pend", pending, 4'd8);
        for (int i = 0; i < 8; i++) begin
            do_res(ord_prod[i], ord_par[i], 1'b0);
            chk($sformatf("t4_code%0d", i), fail_code, 2'd0);
        end
        chk("t4_pass",  pass_cnt, 16'd10);
        chk("t4_pend0", pending,  4'd0);

        // Result with nothing queued
        do_res(32'h0000_0000, 1'b0, 1'b0);
        chk("t5_code",  fail_code, 2'd3);
        chk("t5_fail",  chk_fail,  1'b1);
        chk("t5_unexp", unexp_err, 1'b1);
        chk("t5_fcnt",  fail_cnt,  16'd3);

        // Asynchronous reset with a transaction in flight
        do_req(16'h0002, 16'h0003, 1'b1, 1'b0);
        chk("t6_pend1", pending, 4'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_pending", pending,   4'd0);
        chk("t6_pass",    pass_cnt,  16'd0);
        chk("t6_fcnt",    fail_cnt,  16'd0);
        chk("t6_ovf",     ovf_err,   1'b0);
        chk("t6_unexp",   unexp_err, 1'b0);
        chk("t6_valid",   chk_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef CHK_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            do_req(16'h0005, 16'h0007, 1'b0, 1'b1);
            while (!chk_valid && waited < 100) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("t7_valid",   chk_valid,   1'b1);
            chk("t7_code",    fail_code,   2'd2);
            chk("t7_timeout", timeout_err, 1'b1);
            chk("t7_fcnt",    fail_cnt,    16'd1);
            chk("t7_pending", pending,     4'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
